exe_hazard_forward_ctrl: RTL and testbench
==========================================

// Module: exe_hazard_forward_ctrl
// PURPOSE
//  Sequences the execute stage: tracks dest/WB_en/MEM_r_en of the instructions in EXE, MEM and WB.
//  Drives the EXE operand-mux selects (sel_src_1/2), the load-use stall, and the branch flush.
//  Sits beside the ID/EXE pipeline register. Fed by ID decode fields and branch_taken from EXE.
//  Keeps saturating performance counters for stalls and flushes.
// PARAMETERS
//  FWD_EN        1   1: forwarding on, stall only on load-use; 0: sel always 00, stall on any RAW
//  FLUSH_CYCLES  1   cycles ID acceptance is suppressed after branch_taken (1..7)
//  CNT_W         16  width of stall_cnt / flush_cnt
// PORTS
//  clk           in   1      rising-edge clock
//  rst           in   1      synchronous, active-low reset
//  id_valid      in   1      ID holds a valid instruction
//  id_src1       in   4      Rn index of ID instruction
//  id_src2       in   4      Rm/Rd index of ID instruction
//  id_use_src1   in   1      id_src1 is read
//  id_use_src2   in   1      id_src2 is read
//  id_dest       in   4      destination index
//  id_wb_en      in   1      ID instruction writes back
//  id_mem_r_en   in   1      ID instruction is a load
//  branch_taken  in   1      branch resolved taken in EXE this cycle
//  sel_src_1     out  2      EXE mux 1 select: 00 val_rn, 01 MEM_alu_res, 10 WB_value
//  sel_src_2     out  2      EXE mux 2 select, same encoding
//  hazard_stall  out  1      freeze PC and IF/ID; insert bubble into ID/EXE
//  flush_if_id   out  1      clear IF/ID register
//  flush_id_exe  out  1      clear ID/EXE register
//  stall_cnt     out  CNT_W  cycles with hazard_stall=1, saturating
//  flush_cnt     out  CNT_W  branch flush events, saturating
// BEHAVIOUR
//  - Tracker: three slots EXE/MEM/WB, each {v,dest,wb,mr}. Every cycle WB<=MEM and MEM<=EXE.
//    EXE<=ID fields if accept, else EXE<=bubble (v=0).
//    accept = id_valid & ~hazard_stall & ~flush_id_exe & (state==RUN).
//  - match(slot,src) = slot.v & slot.wb & use_src & (slot.dest==src).
//  - hazard_stall (combinational):
//    - FWD_EN=1: id_valid & state==RUN & EXE.mr & match(EXE, src1|src2).
//    - FWD_EN=0: id_valid & state==RUN & match(EXE or MEM, src1|src2).
//    - The WB slot is never a hazard: the register file writes before it is read.
//  - sel_src_x: registered, loaded on accept:
//    - 01 if match(EXE,srcx), else 10 if match(MEM,srcx), else 00.
//    - EXE has priority (younger result).
//    - Loads 00 on a bubble. Always 00 when FWD_EN=0.
//  - FSM states RUN, FLUSH:
//    - RUN & branch_taken: flush_if_id = flush_id_exe = 1 (combinational, same cycle).
//      hazard_stall forced 0 (branch wins over stall). flush_cnt++.
//      Next state FLUSH with fcnt = FLUSH_CYCLES-1, or RUN if FLUSH_CYCLES==1.
//    - FLUSH: accept=0, flush_if_id=1, branch_taken ignored. fcnt-- each cycle. RUN when fcnt==0.
//  - stall_cnt increments each cycle hazard_stall=1. Both counters hold at all-ones.
//  - Reset (rst=0 at a posedge, including mid-flush or mid-stall):
//    - All slots invalid, sel_src_1/2=00, state=RUN, counters 0.
//    - Combinational outputs are 0 while rst=0.
//  - Latency: sel values valid the cycle the instruction occupies EXE (1 cycle after accept).
//    A load-use stalls exactly 1 cycle (FWD_EN=1). An ALU-use stalls up to 2 cycles (FWD_EN=0).
// TESTING
//  1 Reset: rst=0 for 2 cycles with id_valid=1, branch_taken=1 -> all outputs 0, cnts 0.
//  2 ADD r1 then SUB r2,r1,r3 back-to-back -> hazard_stall=0; sel_src_1=01 while SUB is in EXE.
//  3 ADD r1; NOP; ORR r5,r6,r1 (src2=r1) -> sel_src_2=10, sel_src_1=00 while ORR is in EXE.
//  4 LDR r4 then ADD r5,r4,r6 -> hazard_stall=1 one cycle, stall_cnt=1; ADD in EXE with sel_src_1=10.
//  5 FWD_EN=0: ADD r1 then SUB r2,r1,r3 -> hazard_stall=1 for 2 cycles; sel stays 00.
//  6 FLUSH_CYCLES=2: branch_taken=1 while load-use stall pending -> stall=0, both flushes=1.
//    Then 1 cycle flush_if_id=1, flush_cnt=1; reissued ID accepted on the 3rd cycle.

Source files
------------

// File: rtl/exe_hazard_forward_ctrl.sv
// Execute-stage hazard/forwarding controller: tracks EXE/MEM/WB writers, selects forwarding
// sources, raises the load-use (or RAW) stall and the branch flush, and counts both events.
module exe_hazard_forward_ctrl #(
    parameter bit FWD_EN       = 1'b1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [3:0]       id_src1,
    input  logic [3:0]       id_src2,
    input  logic             id_use_src1,
    input  logic             id_use_src2,
    input  logic [3:0]       id_dest,
    input  logic             id_wb_en,
    input  logic             id_mem_r_en,
    input  logic             branch_taken,
    output logic [1:0]       sel_src_1,
    output logic [1:0]       sel_src_2,
    output logic             hazard_stall,
    output logic             flush_if_id,
    output logic             flush_id_exe,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             dbg_state,
    output logic [6:0]       dbg_wb_slot
);

    typedef struct packed {
        logic       v;
        logic [3:0] dest;
        logic       wb;
        logic       mr;
    } slot_t;

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    localparam logic [2:0]       FCNT_INIT = 3'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    slot_t            exe_q, exe_d, mem_q, mem_d, wb_q, wb_d;
    state_t           state_q, state_d;
    logic [2:0]       fcnt_q, fcnt_d;
    logic [1:0]       sel1_q, sel1_d, sel2_q, sel2_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    logic in_run, branch, accept, hz;
    logic m_exe1, m_exe2, m_mem1, m_mem2;

    function automatic logic match(input slot_t s, input logic use_src, input logic [3:0] src);
        return s.v & s.wb & use_src & (s.dest == src);
    endfunction

    always_comb begin
        in_run = (state_q == RUN);
        m_exe1 = match(exe_q, id_use_src1, id_src1);
        m_exe2 = match(exe_q, id_use_src2, id_src2);
        m_mem1 = match(mem_q, id_use_src1, id_src1);
        m_mem2 = match(mem_q, id_use_src2, id_src2);

        // With forwarding only a load in EXE is too late; without it any in-flight writer blocks.
        if (FWD_EN) hz = exe_q.mr & (m_exe1 | m_exe2);
        else        hz = m_exe1 | m_exe2 | m_mem1 | m_mem2;

        branch       = rst & in_run & branch_taken;
        flush_id_exe = branch;
        flush_if_id  = branch | (rst & ~in_run);
        hazard_stall = rst & id_valid & in_run & ~branch_taken & hz;
        accept       = id_valid & in_run & ~hazard_stall & ~branch;

        exe_d = '0;
        if (accept) exe_d = '{v: 1'b1, dest: id_dest, wb: id_wb_en, mr: id_mem_r_en};
        mem_d = exe_q;
        wb_d  = mem_q;

        // EXE holds the younger result, so it wins over MEM.
        sel1_d = 2'b00;
        sel2_d = 2'b00;
        if (accept && FWD_EN) begin
            if (m_exe1)      sel1_d = 2'b01;
            else if (m_mem1) sel1_d = 2'b10;
            if (m_exe2)      sel2_d = 2'b01;
            else if (m_mem2) sel2_d = 2'b10;
        end

        state_d = state_q;
        fcnt_d  = fcnt_q;
        if (in_run) begin
            if (branch_taken && FLUSH_CYCLES > 1) begin
                state_d = FLUSH;
                fcnt_d  = FCNT_INIT;
            end
        end else if (fcnt_q <= 3'd1) begin
            state_d = RUN;
            fcnt_d  = 3'd0;
        end else begin
            fcnt_d = fcnt_q - 3'd1;
        end

        stall_cnt_d = stall_cnt_q;
        if (hazard_stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_ONE;
        flush_cnt_d = flush_cnt_q;
        if (branch && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            exe_q       <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            state_q     <= RUN;
            fcnt_q      <= 3'd0;
            sel1_q      <= 2'b00;
            sel2_q      <= 2'b00;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            exe_q       <= exe_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            sel1_q      <= sel1_d;
            sel2_q      <= sel2_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign sel_src_1   = sel1_q;
    assign sel_src_2   = sel2_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;
    assign dbg_state   = state_q;
    assign dbg_wb_slot = wb_q;

endmodule

// File: tb/tb_exe_hazard_forward_ctrl.sv
// Bench for exe_hazard_forward_ctrl: instance A (forwarding, 2 flush cycles) and instance B
// (no forwarding, 1 flush cycle, 2-bit counters for saturation), directed vectors.
module tb_exe_hazard_forward_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       a_v, a_u1, a_u2, a_wb, a_mr, a_br;
    logic [3:0] a_s1, a_s2, a_d;
    logic [1:0] a_sel1, a_sel2;
    logic       a_st, a_fif, a_fie, a_dbg_state;
    logic [15:0] a_sc, a_fc;
    logic [6:0] a_dbg_wb;

    logic       b_v, b_u1, b_u2, b_wb, b_mr, b_br;
    logic [3:0] b_s1, b_s2, b_d;
    logic [1:0] b_sel1, b_sel2;
    logic       b_st, b_fif, b_fie, b_dbg_state;
    logic [1:0] b_sc, b_fc;
    logic [6:0] b_dbg_wb;

    exe_hazard_forward_ctrl #(.FWD_EN(1'b1), .FLUSH_CYCLES(2), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .id_valid(a_v), .id_src1(a_s1), .id_src2(a_s2),
        .id_use_src1(a_u1), .id_use_src2(a_u2), .id_dest(a_d), .id_wb_en(a_wb),
        .id_mem_r_en(a_mr), .branch_taken(a_br), .sel_src_1(a_sel1), .sel_src_2(a_sel2),
        .hazard_stall(a_st), .flush_if_id(a_fif), .flush_id_exe(a_fie),
        .stall_cnt(a_sc), .flush_cnt(a_fc), .dbg_state(a_dbg_state), .dbg_wb_slot(a_dbg_wb)
    );

    exe_hazard_forward_ctrl #(.FWD_EN(1'b0), .FLUSH_CYCLES(1), .CNT_W(2)) u_b (
        .clk(clk), .rst(rst), .id_valid(b_v), .id_src1(b_s1), .id_src2(b_s2),
        .id_use_src1(b_u1), .id_use_src2(b_u2), .id_dest(b_d), .id_wb_en(b_wb),
        .id_mem_r_en(b_mr), .branch_taken(b_br), .sel_src_1(b_sel1), .sel_src_2(b_sel2),
        .hazard_stall(b_st), .flush_if_id(b_fif), .flush_id_exe(b_fie),
        .stall_cnt(b_sc), .flush_cnt(b_fc), .dbg_state(b_dbg_state), .dbg_wb_slot(b_dbg_wb)
    );

    // Record: [39] inst, [38] stall, [37] flush_if_id, [36] flush_id_exe,
    // [35:34] sel1, [33:32] sel2, [31:16] stall_cnt, [15:0] flush_cnt.
    logic [39:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [39:0] rec(input logic inst, input logic st, input logic fif,
                                        input logic fie, input logic [1:0] s1, input logic [1:0] s2,
                                        input logic [15:0] sc, input logic [15:0] fc);
        return {inst, st, fif, fie, s1, s2, sc, fc};
    endfunction

    task automatic chk(input string name, input logic inst, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d t=%0t: got %0h expected %0h", name, inst, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [39:0] e, a;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e[39]) a = rec(1'b1, b_st, b_fif, b_fie, b_sel1, b_sel2, {14'b0, b_sc}, {14'b0, b_fc});
            else       a = rec(1'b0, a_st, a_fif, a_fie, a_sel1, a_sel2, a_sc, a_fc);
            chk("hazard_stall", e[39], 16'(a[38]), 16'(e[38]));
            chk("flush_if_id", e[39], 16'(a[37]), 16'(e[37]));
            chk("flush_id_exe", e[39], 16'(a[36]), 16'(e[36]));
            chk("sel_src_1", e[39], 16'(a[35:34]), 16'(e[35:34]));
            chk("sel_src_2", e[39], 16'(a[33:32]), 16'(e[33:32]));
            chk("stall_cnt", e[39], a[31:16], e[31:16]);
            chk("flush_cnt", e[39], a[15:0], e[15:0]);
        end
    end

    task automatic set_in(input logic inst, input logic v, input logic [3:0] s1, input logic u1,
                          input logic [3:0] s2, input logic u2, input logic [3:0] d,
                          input logic wb, input logic mr, input logic br);
        if (!inst) begin
            a_v = v; a_s1 = s1; a_u1 = u1; a_s2 = s2; a_u2 = u2; a_d = d; a_wb = wb; a_mr = mr; a_br = br;
        end else begin
            b_v = v; b_s1 = s1; b_u1 = u1; b_s2 = s2; b_u2 = u2; b_d = d; b_wb = wb; b_mr = mr; b_br = br;
        end
    endtask

    // Drives one instance for one cycle (other instance idle) and queues its expected outputs.
    task automatic cyc(input logic inst, input logic v, input logic [3:0] s1, input logic u1,
                       input logic [3:0] s2, input logic u2, input logic [3:0] d, input logic wb,
                       input logic mr, input logic br, input logic e_st, input logic e_fif,
                       input logic e_fie, input logic [1:0] e_s1, input logic [1:0] e_s2,
                       input logic [15:0] e_sc, input logic [15:0] e_fc);
        set_in(inst, v, s1, u1, s2, u2, d, wb, mr, br);
        set_in(~inst, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(rec(inst, e_st, e_fif, e_fie, e_s1, e_s2, e_sc, e_fc));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic inst, input logic br, input logic e_fif, input logic e_fie,
                        input logic [1:0] e_s1, input logic [1:0] e_s2,
                        input logic [15:0] e_sc, input logic [15:0] e_fc);
        cyc(inst, 0, 0, 0, 0, 0, 0, 0, 0, br, 1'b0, e_fif, e_fie, e_s1, e_s2, e_sc, e_fc);
    endtask

    initial begin
        // Reset held with valid + branch asserted: everything must read 0.
        set_in(0, 1, 1, 1, 1, 1, 1, 1, 1, 1);
        set_in(1, 1, 1, 1, 1, 1, 1, 1, 1, 1);
        @(posedge clk);
        #1;
        repeat (2) begin
            exp_q.push_back(rec(0, 0, 0, 0, 0, 0, 0, 0));
            exp_q.push_back(rec(1, 0, 0, 0, 0, 0, 0, 0));
            @(posedge clk);
            #1;
        end
        rst = 1'b1;

        // A: ADD r1,r2,r3 ; SUB r2,r1,r3 -> EXE forward on src1
        cyc(0, 1, 2, 1, 3, 1, 1, 1, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0, 0);
        cyc(0, 1, 1, 1, 3, 1, 2, 1, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0, 0);
        idle(0, 0, 0, 0, 2'b01, 2'b00, 0, 0);
        idle(0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        idle(0, 0, 0, 0, 2'b00, 2'b00, 0, 0);

        // A: ADD r1 ; NOP ; ORR r5,r6,r1 -> MEM forward on src2
        cyc(0, 1, 2, 1, 3, 1, 1, 1, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0, 0);
        idle(0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        cyc(0, 1, 6, 1, 1, 1, 5, 1, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0, 0);
        idle(0, 0, 0, 0, 2'b00, 2'b10, 0, 0);
        idle(0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        idle(0, 0, 0, 0, 2'b00, 2'b00, 0, 0);

        // A: LDR r4 ; ADD r5,r4,r6 -> one stall, then MEM forward
        cyc(0, 1, 7, 1, 0, 0, 4, 1, 1, 0,  0, 0, 0, 2'b00, 2'b00, 0, 0);
        cyc(0, 1, 4, 1, 6, 1, 5, 1, 0, 0,  1, 0, 0, 2'b00, 2'b00, 0, 0);
        cyc(0, 1, 4, 1, 6, 1, 5, 1, 0, 0,  0, 0, 0, 2'b00, 2'b00, 1, 0);
        idle(0, 0, 0, 0, 2'b10, 2'b00, 1, 0);
        idle(0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
        idle(0, 0, 0, 0, 2'b00, 2'b00, 1, 0);

        // A: LDR r4 ; consumer names r4 but does not read it -> no stall
        cyc(0, 1, 7, 1, 0, 0, 4, 1, 1, 0,  0, 0, 0, 2'b00, 2'b00, 1, 0);
        cyc(0, 1, 4, 0, 4, 0, 8, 1, 0, 0,  0, 0, 0, 2'b00, 2'b00, 1, 0);
        idle(0, 0, 0, 0, 2'b00, 2'b00, 1, 0);

        // A: ADD r1 ; ADD r1 ; SUB r2,r1,r1 -> EXE wins over MEM on both sources
        cyc(0, 1, 2, 1, 3, 1, 1, 1, 0, 0,  0, 0, 0, 2'b00, 2'b00, 1, 0);
        cyc(0, 1, 2, 1, 3, 1, 1, 1, 0, 0,  0, 0, 0, 2'b00, 2'b00, 1, 0);
        cyc(0, 1, 1, 1, 1, 1, 2, 1, 0, 0,  0, 0, 0, 2'b00, 2'b00, 1, 0);
        idle(0, 0, 0, 0, 2'b01, 2'b01, 1, 0);
        idle(0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
        idle(0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
        idle(0, 0, 0, 0, 2'b00, 2'b00, 1, 0);

        // A: branch during pending load-use, FLUSH_CYCLES=2
        cyc(0, 1, 7, 1, 0, 0, 4, 1, 1, 0,  0, 0, 0, 2'b00, 2'b00, 1, 0);
        cyc(0, 1, 4, 1, 6, 1, 5, 1, 0, 1,  0, 1, 1, 2'b00, 2'b00, 1, 0);
        cyc(0, 1, 4, 1, 6, 1, 5, 1, 0, 1,  0, 1, 0, 2'b00, 2'b00, 1, 1);
        cyc(0, 1, 4, 1, 6, 1, 5, 1, 0, 0,  0, 0, 0, 2'b00, 2'b00, 1, 1);
        cyc(0, 1, 5, 1, 9, 1, 2, 1, 0, 0,  0, 0, 0, 2'b00, 2'b00, 1, 1);
        idle(0, 0, 0, 0, 2'b01, 2'b00, 1, 1);
        idle(0, 0, 0, 0, 2'b00, 2'b00, 1, 1);

        // A: reset asserted while a load-use and a branch are presented
        cyc(0, 1, 7, 1, 0, 0, 4, 1, 1, 0,  0, 0, 0, 2'b00, 2'b00, 1, 1);
        rst = 1'b0;
        cyc(0, 1, 4, 1, 6, 1, 5, 1, 0, 1,  0, 0, 0, 2'b00, 2'b00, 1, 1);
        idle(0, 1, 0, 0, 2'b00, 2'b00, 0, 0);
        rst = 1'b1;
        idle(0, 0, 0, 0, 2'b00, 2'b00, 0, 0);

        // B: ADD r1 ; SUB r2,r1,r3 without forwarding -> two stalls, sel stays 00
        cyc(1, 1, 2, 1, 3, 1, 1, 1, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0, 0);
        cyc(1, 1, 1, 1, 3, 1, 2, 1, 0, 0,  1, 0, 0, 2'b00, 2'b00, 0, 0);
        cyc(1, 1, 1, 1, 3, 1, 2, 1, 0, 0,  1, 0, 0, 2'b00, 2'b00, 1, 0);
        cyc(1, 1, 1, 1, 3, 1, 2, 1, 0, 0,  0, 0, 0, 2'b00, 2'b00, 2, 0);
        idle(1, 0, 0, 0, 2'b00, 2'b00, 2, 0);

        // B: two more stalls drive the 2-bit stall counter into saturation
        cyc(1, 1, 7, 1, 0, 0, 4, 1, 1, 0,  0, 0, 0, 2'b00, 2'b00, 2, 0);
        cyc(1, 1, 4, 1, 6, 1, 5, 1, 0, 0,  1, 0, 0, 2'b00, 2'b00, 2, 0);
        cyc(1, 1, 4, 1, 6, 1, 5, 1, 0, 0,  1, 0, 0, 2'b00, 2'b00, 3, 0);
        cyc(1, 1, 4, 1, 6, 1, 5, 1, 0, 0,  0, 0, 0, 2'b00, 2'b00, 3, 0);
        idle(1, 0, 0, 0, 2'b00, 2'b00, 3, 0);
        idle(1, 0, 0, 0, 2'b00, 2'b00, 3, 0);
        idle(1, 0, 0, 0, 2'b00, 2'b00, 3, 0);

        // B: branch beats a RAW stall; back-to-back branches saturate the flush counter
        cyc(1, 1, 2, 1, 3, 1, 1, 1, 0, 0,  0, 0, 0, 2'b00, 2'b00, 3, 0);
        cyc(1, 1, 1, 1, 3, 1, 2, 1, 0, 1,  0, 1, 1, 2'b00, 2'b00, 3, 0);
        idle(1, 1, 1, 1, 2'b00, 2'b00, 3, 1);
        idle(1, 1, 1, 1, 2'b00, 2'b00, 3, 2);
        idle(1, 1, 1, 1, 2'b00, 2'b00, 3, 3);
        idle(1, 0, 0, 0, 2'b00, 2'b00, 3, 3);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
